// File: rtl/board_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_fetch_ctrl
//  Description : Sequencer for the board drawing stage. Fetches four game
//                settings words over one Wishbone master on start, then
//                rescans board memory over a second master on every rising
//                edge of vblnk, filling a local cell cache that the pixel
//                datapath reads with one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_fetch_ctrl #(
    parameter int MAX_BUTTONS = 16,
    parameter int WB_TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        vblnk_i,
    // settings master
    output logic [7:0]  game_adr_o,
    input  logic [15:0] game_dat_i,
    output logic        game_cyc_o,
    output logic        game_stb_o,
    output logic        game_we_o,
    input  logic        game_ack_i,
    // board memory master
    output logic [7:0]  board_adr_o,
    input  logic [15:0] board_dat_i,
    output logic        board_cyc_o,
    output logic        board_stb_o,
    output logic        board_we_o,
    input  logic        board_ack_i,
    // latched settings
    output logic [10:0] board_xpos_o,
    output logic [10:0] board_ypos_o,
    output logic [10:0] board_size_o,
    output logic [5:0]  button_size_o,
    output logic [4:0]  button_num_o,
    output logic        settings_valid_o,
    // cache read port
    input  logic [3:0]  rd_row_i,
    input  logic [3:0]  rd_col_i,
    output logic [3:0]  rd_cell_o,
    // status
    output logic        frame_done_o,
    output logic        wb_err_o,
    output logic        scan_overrun_o
);

    // Counter is one bit wider than needed so it never wraps on the abort edge.
    localparam int               CNT_W       = $clog2(WB_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(WB_TIMEOUT);
    localparam int               CACHE_DEPTH = MAX_BUTTONS * MAX_BUTTONS;
    localparam int               CIDX_W      = $clog2(CACHE_DEPTH);
    localparam logic [4:0]       NUM_MAX     = 5'(MAX_BUTTONS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SET_RD  = 2'd1,
        S_WAIT_VB = 2'd2,
        S_SCAN    = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         widx_q;
    logic [3:0]         row_q;
    logic [3:0]         col_q;
    logic               vblnk_q;
    logic [CNT_W-1:0]   tmo_q;

    logic [7:0]         game_adr_q;
    logic               game_cyc_q;
    logic               game_stb_q;
    logic [7:0]         board_adr_q;
    logic               board_cyc_q;
    logic               board_stb_q;

    logic [10:0]        board_xpos_q;
    logic [10:0]        board_ypos_q;
    logic [10:0]        board_size_q;
    logic [5:0]         button_size_q;
    logic [4:0]         button_num_q;
    logic               settings_valid_q;
    logic               frame_done_q;
    logic               wb_err_q;
    logic               scan_overrun_q;
    logic [3:0]         rd_cell_q;

    logic [3:0]         cache_q [CACHE_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [4:0]         num_raw_d;
    logic [4:0]         num_clamped_d;
    logic [4:0]         num_m1_d;
    logic               col_last_d;
    logic               row_last_d;
    logic               stb_any_d;
    logic               ack_any_d;
    logic               tmo_hit_d;
    logic               vb_rise_d;
    logic               vb_fall_d;
    logic               cache_we_d;
    logic [CIDX_W-1:0]  wr_idx_d;
    logic [CIDX_W-1:0]  rd_idx_d;

    assign num_raw_d     = game_dat_i[12:8];
    assign num_clamped_d = (num_raw_d > NUM_MAX) ? NUM_MAX : num_raw_d;
    assign num_m1_d      = button_num_q - 5'd1;
    assign col_last_d    = ({1'b0, col_q} == num_m1_d);
    assign row_last_d    = ({1'b0, row_q} == num_m1_d);

    // Only one master is ever active, so one transfer timer serves both.
    assign stb_any_d     = game_stb_q | board_stb_q;
    assign ack_any_d     = (game_stb_q & game_ack_i) | (board_stb_q & board_ack_i);
    assign tmo_hit_d     = (tmo_q == TMO_LAST);

    assign vb_rise_d     = ~vblnk_q & vblnk_i;
    assign vb_fall_d     = vblnk_q & ~vblnk_i;

    assign cache_we_d    = (state_q == S_SCAN) & board_stb_q & board_ack_i;
    assign wr_idx_d      = CIDX_W'(int'(row_q) * MAX_BUTTONS + int'(col_q));
    assign rd_idx_d      = CIDX_W'(int'(rd_row_i) * MAX_BUTTONS + int'(rd_col_i));

    // ------------------------------------------------------------------
    // Sequencer: settings fetch, frame scan, bus handshakes and status.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            widx_q           <= 2'd0;
            row_q            <= 4'd0;
            col_q            <= 4'd0;
            vblnk_q          <= 1'b0;
            tmo_q            <= '0;
            game_adr_q       <= 8'd0;
            game_cyc_q       <= 1'b0;
            game_stb_q       <= 1'b0;
            board_adr_q      <= 8'd0;
            board_cyc_q      <= 1'b0;
            board_stb_q      <= 1'b0;
            board_xpos_q     <= 11'd0;
            board_ypos_q     <= 11'd0;
            board_size_q     <= 11'd0;
            button_size_q    <= 6'd0;
            button_num_q     <= 5'd0;
            settings_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
            wb_err_q         <= 1'b0;
            scan_overrun_q   <= 1'b0;
        end else begin
            vblnk_q      <= vblnk_i;
            frame_done_q <= 1'b0;

            // Counts waiting cycles of the current request; cleared otherwise.
            if (stb_any_d && !ack_any_d) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        settings_valid_q <= 1'b0;
                        widx_q           <= 2'd0;
                        state_q          <= S_SET_RD;
                    end
                end

                S_SET_RD: begin
                    if (!game_stb_q) begin
                        // Idle cycle just elapsed; issue the next settings read.
                        game_cyc_q <= 1'b1;
                        game_stb_q <= 1'b1;
                        game_adr_q <= {6'd0, widx_q};
                    end else if (game_ack_i) begin
                        game_cyc_q <= 1'b0;
                        game_stb_q <= 1'b0;
                        widx_q     <= widx_q + 2'd1;
                        case (widx_q)
                            2'd0: board_xpos_q <= game_dat_i[10:0];
                            2'd1: board_ypos_q <= game_dat_i[10:0];
                            2'd2: board_size_q <= game_dat_i[10:0];
                            default: begin
                                button_size_q    <= game_dat_i[5:0];
                                button_num_q     <= num_clamped_d;
                                settings_valid_q <= 1'b1;
                                state_q          <= S_WAIT_VB;
                            end
                        endcase
                    end else if (tmo_hit_d) begin
                        game_cyc_q       <= 1'b0;
                        game_stb_q       <= 1'b0;
                        wb_err_q         <= 1'b1;
                        settings_valid_q <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end

                S_WAIT_VB: begin
                    if (vb_rise_d) begin
                        row_q   <= 4'd0;
                        col_q   <= 4'd0;
                        state_q <= S_SCAN;
                        // An empty board completes on its first scan cycle.
                        if (button_num_q == 5'd0) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end

                S_SCAN: begin
                    if (vb_fall_d) begin
                        scan_overrun_q <= 1'b1;
                    end
                    if (button_num_q == 5'd0) begin
                        state_q <= S_WAIT_VB;
                    end else if (!board_stb_q) begin
                        board_cyc_q <= 1'b1;
                        board_stb_q <= 1'b1;
                        board_adr_q <= {row_q, col_q};
                    end else if (board_ack_i) begin
                        board_cyc_q <= 1'b0;
                        board_stb_q <= 1'b0;
                        if (col_last_d) begin
                            col_q <= 4'd0;
                            if (row_last_d) begin
                                frame_done_q <= 1'b1;
                                state_q      <= S_WAIT_VB;
                            end else begin
                                row_q <= row_q + 4'd1;
                            end
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end else if (tmo_hit_d) begin
                        // Abandon the frame; unread cells keep stale contents.
                        board_cyc_q <= 1'b0;
                        board_stb_q <= 1'b0;
                        wb_err_q    <= 1'b1;
                        state_q     <= S_WAIT_VB;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Cache write port: cells land on the edge their board read is acked.
    always_ff @(posedge clk_i) begin
        if (cache_we_d) begin
            cache_q[wr_idx_d] <= board_dat_i[3:0];
        end
    end

    // Cache read port: registered, so a same-cycle write is not visible yet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cell_q <= 4'd0;
        end else begin
            rd_cell_q <= cache_q[rd_idx_d];
        end
    end

    assign game_adr_o       = game_adr_q;
    assign game_cyc_o       = game_cyc_q;
    assign game_stb_o       = game_stb_q;
    assign game_we_o        = 1'b0;
    assign board_adr_o      = board_adr_q;
    assign board_cyc_o      = board_cyc_q;
    assign board_stb_o      = board_stb_q;
    assign board_we_o       = 1'b0;
    assign board_xpos_o     = board_xpos_q;
    assign board_ypos_o     = board_ypos_q;
    assign board_size_o     = board_size_q;
    assign button_size_o    = button_size_q;
    assign button_num_o     = button_num_q;
    assign settings_valid_o = settings_valid_q;
    assign rd_cell_o        = rd_cell_q;
    assign frame_done_o     = frame_done_q;
    assign wb_err_o         = wb_err_q;
    assign scan_overrun_o   = scan_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_board_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_fetch_ctrl
//  Description : Self-checking bench for board_fetch_ctrl with Wishbone slave
//                models, a cache scoreboard and directed plus random steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_fetch_ctrl;

    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        vblnk;
    logic [7:0]  game_adr;
    logic [15:0] game_dat;
    logic        game_cyc, game_stb, game_we, game_ack;
    logic [7:0]  board_adr;
    logic [15:0] board_dat;
    logic        board_cyc, board_stb, board_we, board_ack;
    logic [10:0] xpos, ypos, bsize;
    logic [5:0]  btn_size;
    logic [4:0]  btn_num;
    logic        svalid;
    logic [3:0]  rd_row, rd_col, rd_cell;
    logic        frame_done, wb_err, overrun;

    int total = 0;
    int bad   = 0;

    // slave models
    logic [15:0] gset [4];
    logic [15:0] bmem [256];
    logic        rnd_wait = 1'b0;
    logic        stall_en = 1'b0;
    logic [7:0]  stall_adr = 8'h00;
    int          gw_cnt = 0, gwait = 0, bw_cnt = 0, bwait = 0;
    logic [7:0]  blog [8192];
    logic [7:0]  glog [1024];
    int          blog_n = 0, glog_n = 0, bstb_n = 0, gstb_n = 0, fd_n = 0;

    // reference cache model
    logic [3:0]  exp_cache [256];
    logic        exp_valid [256];

    board_fetch_ctrl #(.MAX_BUTTONS(16), .WB_TIMEOUT(255)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .vblnk_i(vblnk),
        .game_adr_o(game_adr), .game_dat_i(game_dat), .game_cyc_o(game_cyc),
        .game_stb_o(game_stb), .game_we_o(game_we), .game_ack_i(game_ack),
        .board_adr_o(board_adr), .board_dat_i(board_dat), .board_cyc_o(board_cyc),
        .board_stb_o(board_stb), .board_we_o(board_we), .board_ack_i(board_ack),
        .board_xpos_o(xpos), .board_ypos_o(ypos), .board_size_o(bsize),
        .button_size_o(btn_size), .button_num_o(btn_num), .settings_valid_o(svalid),
        .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_cell_o(rd_cell),
        .frame_done_o(frame_done), .wb_err_o(wb_err), .scan_overrun_o(overrun)
    );

    always #5 clk = ~clk;

    assign game_dat  = gset[game_adr[1:0]];
    assign board_dat = bmem[board_adr];

    always_comb game_ack  = game_cyc && game_stb && (gw_cnt >= gwait);
    always_comb board_ack = board_cyc && board_stb && (bw_cnt >= bwait)
                            && !(stall_en && board_adr == stall_adr);

    // Slave wait-state counters and transaction logging.
    always @(posedge clk) begin
        if (board_stb && !board_ack) bw_cnt <= bw_cnt + 1; else bw_cnt <= 0;
        if (game_stb && !game_ack) gw_cnt <= gw_cnt + 1; else gw_cnt <= 0;
        if (board_stb && board_ack) begin
            if (blog_n < 8192) blog[blog_n] <= board_adr;
            blog_n <= blog_n + 1;
            bwait  <= rnd_wait ? int'($urandom_range(0, 2)) : 0;
        end
        if (game_stb && game_ack) begin
            if (glog_n < 1024) glog[glog_n] <= game_adr;
            glog_n <= glog_n + 1;
            gwait  <= rnd_wait ? int'($urandom_range(0, 3)) : 0;
        end
        if (board_stb) bstb_n <= bstb_n + 1;
        if (game_stb)  gstb_n <= gstb_n + 1;
        if (frame_done) fd_n <= fd_n + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] all_outputs();
        return {game_cyc, game_stb, game_we, game_adr, board_cyc, board_stb, board_we,
                board_adr, xpos, ypos, bsize, btn_size, btn_num, svalid, rd_cell,
                frame_done, wb_err, overrun};
    endfunction

    function automatic int exp_num(input logic [15:0] w3);
        int n = int'((w3 >> 8) & 16'h1F);
        return (n > 16) ? 16 : n;
    endfunction

    // Edge count from the edge that samples the vblnk rise to frame_done:
    // SCAN starts one cycle later, each cell is an idle+request pair, and
    // frame_done follows the last ack; an empty board flags on entry.
    function automatic int exp_scan_edges(input int n);
        return (n == 0) ? 1 : 2 * n * n + 1;
    endfunction

    task automatic apply_reset;
        #1 rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
    endtask

    // Pulse start and count edges (start-sampling edge = 1) to settings_valid.
    task automatic fetch(input logic [15:0] w0, w1, w2, w3, output int n);
        gset[0] = w0; gset[1] = w1; gset[2] = w2; gset[3] = w3;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (svalid !== 1'b1 && n < LIMIT) begin tick; n++; end
    endtask

    task automatic check_settings(input string tag);
        check({tag, "_xpos"},  96'(xpos),     96'(gset[0] & 16'h07FF));
        check({tag, "_ypos"},  96'(ypos),     96'(gset[1] & 16'h07FF));
        check({tag, "_size"},  96'(bsize),    96'(gset[2] & 16'h07FF));
        check({tag, "_bsize"}, 96'(btn_size), 96'(gset[3] & 16'h003F));
        check({tag, "_bnum"},  96'(btn_num),  96'(exp_num(gset[3])));
    endtask

    task automatic run_scan(input int drop_at, input int start_at, output int n);
        vblnk = 1'b0; tick; tick;
        vblnk = 1'b1; tick;
        n = 1;
        while (frame_done !== 1'b1 && n < LIMIT) begin
            if (n == drop_at) vblnk = 1'b0;
            start = (n == start_at);
            tick;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic model_scan(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                exp_cache[r * 16 + c] = bmem[r * 16 + c][3:0];
                exp_valid[r * 16 + c] = 1'b1;
            end
    endtask

    task automatic check_addrs(input string tag, input int first, input int n);
        int i = 0;
        check({tag, "_nreads"}, 96'(blog_n - first), 96'(n * n));
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (first + i < blog_n)
                    check($sformatf("%s_adr%0d", tag, i), 96'(blog[first + i]), 96'((r << 4) | c));
                i++;
            end
    endtask

    task automatic readback(input string tag);
        for (int idx = 0; idx < 256; idx++) begin
            if (exp_valid[idx]) begin
                rd_row = 4'(idx / 16);
                rd_col = 4'(idx % 16);
                tick;
                check($sformatf("%s_cell_%0d_%0d", tag, idx / 16, idx % 16),
                      96'(rd_cell), 96'(exp_cache[idx]));
            end
        end
    endtask

    task automatic fill_bmem;
        for (int i = 0; i < 256; i++) bmem[i] = 16'($urandom);
    endtask

    initial begin
        int n, m, b0, g0, s0, f0, w;
        rst_n = 1'b0; start = 1'b0; vblnk = 1'b0; rd_row = 4'd0; rd_col = 4'd0;
        for (int i = 0; i < 4; i++) gset[i] = 16'h0;
        for (int i = 0; i < 256; i++) begin exp_valid[i] = 1'b0; exp_cache[i] = 4'd0; end
        tick; tick; tick;
        check("reset_outputs", 96'(all_outputs()), 96'd0);
        rst_n = 1'b1;
        tick;

        // ---- settings fetch, zero wait ----
        g0 = glog_n;
        fetch(16'h0064, 16'h0032, 16'h0190, 16'h0A19, n);
        check("fetch_latency", 96'(n), 96'd9);
        check("fetch_xpos", 96'(xpos), 96'd100);
        check("fetch_ypos", 96'(ypos), 96'd50);
        check("fetch_size", 96'(bsize), 96'd400);
        check("fetch_bsize", 96'(btn_size), 96'd25);
        check("fetch_bnum", 96'(btn_num), 96'd10);
        check("fetch_nreads", 96'(glog_n - g0), 96'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fetch_adr%0d", i), 96'(glog[g0 + i]), 96'(i));

        // ---- full scan N=10, cell = (row+col)&15 ----
        for (int i = 0; i < 256; i++)
            bmem[i] = {12'($urandom), 4'(((i >> 4) + (i & 15)) & 15)};
        b0 = blog_n;
        run_scan(-1, -1, n);
        check("scan10_frame_done", 96'(frame_done), 96'd1);
        check("scan10_cycles", 96'(n), 96'(exp_scan_edges(10)));
        check_addrs("scan10", b0, 10);
        model_scan(10);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                rd_row = 4'(r); rd_col = 4'(c);
                tick;
                check($sformatf("sum_cell_%0d_%0d", r, c), 96'(rd_cell), 96'((r + c) & 15));
            end
        check("scan10_overrun", 96'(overrun), 96'd0);
        check("scan10_wberr", 96'(wb_err), 96'd0);

        // ---- overrun and ignored start ----
        fill_bmem();
        g0 = gstb_n;
        b0 = blog_n;
        run_scan(50, 60, n);
        check("ovr_cycles", 96'(n), 96'(exp_scan_edges(10)));
        check("ovr_flag", 96'(overrun), 96'd1);
        check("ovr_no_game_req", 96'(gstb_n - g0), 96'd0);
        check("ovr_svalid", 96'(svalid), 96'd1);
        check_addrs("ovr", b0, 10);
        model_scan(10);
        readback("ovr");

        // ---- timeout on cell (0,3) ----
        fill_bmem();
        stall_en = 1'b1; stall_adr = 8'h03;
        b0 = blog_n; f0 = fd_n;
        vblnk = 1'b0; tick; tick; vblnk = 1'b1; tick;
        w = 0;
        while (!(board_stb && board_adr == 8'h03) && w < 100) begin tick; w++; end
        check("tmo_reached_cell3", 96'(board_stb && board_adr == 8'h03), 96'd1);
        m = 0;
        while (board_stb && m < 400) begin tick; m++; end
        check("tmo_stb_cycles", 96'(m), 96'd256);
        check("tmo_cyc_low", 96'(board_cyc), 96'd0);
        check("tmo_wberr", 96'(wb_err), 96'd1);
        for (int i = 0; i < 20; i++) tick;
        check("tmo_no_frame_done", 96'(fd_n - f0), 96'd0);
        check("tmo_nreads", 96'(blog_n - b0), 96'd3);
        for (int c = 0; c < 3; c++) begin
            exp_cache[c] = bmem[c][3:0];
            exp_valid[c] = 1'b1;
        end
        readback("tmo");
        stall_en = 1'b0;
        b0 = blog_n;
        run_scan(-1, -1, n);
        check("tmo_restart_cycles", 96'(n), 96'(exp_scan_edges(10)));
        check_addrs("tmo_restart", b0, 10);
        model_scan(10);
        readback("tmo_restart");

        // ---- asynchronous reset mid-transfer ----
        stall_en = 1'b1; stall_adr = 8'h25;
        vblnk = 1'b0; tick; tick; vblnk = 1'b1; tick;
        w = 0;
        while (!(board_stb && board_adr == 8'h25) && w < LIMIT) begin tick; w++; end
        check("rst_reached_cell", 96'(board_stb), 96'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_async_outputs", 96'(all_outputs()), 96'd0);
        stall_en = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;

        // ---- clamp: num field 31 -> 16 ----
        fetch(16'h0010, 16'h0020, 16'h0030, 16'h1F00, n);
        check_settings("clamp");
        fill_bmem();
        b0 = blog_n;
        run_scan(-1, -1, n);
        check("clamp_cycles", 96'(n), 96'(exp_scan_edges(16)));
        check_addrs("clamp", b0, 16);
        model_scan(16);
        readback("clamp");

        // ---- empty board ----
        apply_reset();
        fetch(16'h0001, 16'h0002, 16'h0003, 16'h0000, n);
        check("empty_bnum", 96'(btn_num), 96'd0);
        s0 = bstb_n; f0 = fd_n;
        run_scan(-1, -1, n);
        check("empty_cycles", 96'(n), 96'(exp_scan_edges(0)));
        for (int i = 0; i < 10; i++) tick;
        check("empty_no_stb", 96'(bstb_n - s0), 96'd0);
        check("empty_one_pulse", 96'(fd_n - f0), 96'd1);

        // ---- randomized rounds with wait states ----
        rnd_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            fetch(16'($urandom), 16'($urandom), 16'($urandom),
                  {3'b000, 5'($urandom_range(1, 31)), 8'($urandom)}, n);
            check($sformatf("rnd%0d_svalid", k), 96'(svalid), 96'd1);
            check_settings($sformatf("rnd%0d", k));
            fill_bmem();
            b0 = blog_n;
            run_scan(-1, -1, n);
            check($sformatf("rnd%0d_frame_done", k), 96'(frame_done), 96'd1);
            check_addrs($sformatf("rnd%0d", k), b0, exp_num(gset[3]));
            model_scan(exp_num(gset[3]));
            readback($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
